// File: rtl/frame_pkg.sv
// Shared definitions for the frame assembler and the downstream frame unpacker:
// default widths, word-count derivation, frame counter width and FSM states.
package frame_pkg;

    localparam int IN_WIDTH_DEF  = 32;
    localparam int DATAWIDTH_DEF = 512;
    localparam int FRAME_COUNT_W = 16;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } frame_state_e;

    function automatic int words_of(input int data_width, input int in_width);
        return data_width / in_width;
    endfunction

    // A single-word frame still needs a one-bit index register.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/frame_assembler_if.sv
// Host word stream plus frame output bundle between host, assembler and unpacker.
interface frame_assembler_if
    import frame_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int DATAWIDTH = DATAWIDTH_DEF
);
    logic [IN_WIDTH-1:0]      s_data;
    logic                     s_valid;
    logic                     s_last;
    logic                     s_ready;
    logic [DATAWIDTH-1:0]     frame_data;
    logic                     wr_ready;
    logic                     wr_done;
    logic [FRAME_COUNT_W-1:0] frame_count;

    modport master (
        output s_data, s_valid, s_last,
        input  s_ready, frame_data, wr_ready, wr_done, frame_count
    );

    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready, frame_data, wr_ready, wr_done, frame_count
    );
endinterface

// File: rtl/word_packer.sv
// Accumulates host words into a zero-padded frame; packed_frame already includes
// the word being written this cycle. Build with FRAME_ASM_BYTESWAP_EN to byte-reverse words.
module word_packer
    import frame_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [IN_WIDTH-1:0]  word,
    output logic [DATAWIDTH-1:0] packed_frame,
    output logic                 full
);
    localparam int WORDS = words_of(DATAWIDTH, IN_WIDTH);
    localparam int IDX_W = idx_width(WORDS);

    logic [DATAWIDTH-1:0] acc;
    logic [IDX_W-1:0]     idx;
    logic [IN_WIDTH-1:0]  word_in;

`ifdef FRAME_ASM_BYTESWAP_EN
    always_comb begin
        word_in = '0;
        for (int b = 0; b < IN_WIDTH / 8; b++) begin
            word_in[b*8 +: 8] = word[IN_WIDTH-8-b*8 +: 8];
        end
    end
`else
    assign word_in = word;
`endif

    assign full = (idx == IDX_W'(WORDS - 1));

    always_comb begin
        packed_frame = acc;
        if (wr_en) begin
            packed_frame[int'(idx)*IN_WIDTH +: IN_WIDTH] = word_in;
        end
    end

    // Clearing wins over a simultaneous write: the completing word leaves via packed_frame.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            idx <= '0;
        end else if (wr_en) begin
            acc <= packed_frame;
            idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/frame_assembler.sv
// Gathers host words into DATAWIDTH-bit frames for the unpacker and signals end of transfer
// after a drain gap. Optional build macro: FRAME_ASM_BYTESWAP_EN (byte-reverse host words).
//
// state | meaning
// FILL  | accepting words, emitting a frame on full or s_last
// DRAIN | s_ready low, counting DRAIN_CYCLES idle cycles after the final frame
// DONE  | one-cycle wr_done pulse, then frame_count cleared
module frame_assembler
    import frame_pkg::*;
#(
    parameter int IN_WIDTH     = IN_WIDTH_DEF,
    parameter int DATAWIDTH    = DATAWIDTH_DEF,
    parameter int DRAIN_CYCLES = 2
) (
    input logic          clk,
    input logic          rst,
    frame_assembler_if.slave bus
);
    localparam logic [1:0] ST_FILL  = FILL;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]               state;
    logic [3:0]               drain_cnt;
    logic [DATAWIDTH-1:0]     frame_q;
    logic                     wr_ready_q;
    logic [FRAME_COUNT_W-1:0] count_q;
    logic                     s_ready;
    logic                     accept;
    logic                     frame_end;
    logic                     full;
    logic [DATAWIDTH-1:0]     packed_frame;

    // Gated by rst so s_ready stays low while reset is held and rises on the first free cycle.
    assign s_ready   = (state == ST_FILL) && !rst;
    assign accept    = bus.s_valid && s_ready;
    assign frame_end = accept && (full || bus.s_last);

    word_packer #(
        .IN_WIDTH  (IN_WIDTH),
        .DATAWIDTH (DATAWIDTH)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear        (frame_end),
        .wr_en        (accept),
        .word         (bus.s_data),
        .packed_frame (packed_frame),
        .full         (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FILL;
            drain_cnt  <= '0;
            frame_q    <= '0;
            wr_ready_q <= 1'b0;
            count_q    <= '0;
        end else begin
            wr_ready_q <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (frame_end) begin
                        frame_q    <= packed_frame;
                        wr_ready_q <= 1'b1;
                        if (count_q != '1) begin
                            count_q <= count_q + FRAME_COUNT_W'(1);
                        end
                        if (bus.s_last) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= 4'(DRAIN_CYCLES);
                        end
                    end
                end
                // The strobe cycle itself is the first DRAIN cycle, so terminal count
                // is reached DRAIN_CYCLES idle cycles after the strobe.
                ST_DRAIN: begin
                    if (drain_cnt == 4'd0) begin
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    count_q <= '0;
                    state   <= ST_FILL;
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    assign bus.s_ready     = s_ready;
    assign bus.frame_data  = frame_q;
    assign bus.wr_ready    = wr_ready_q;
    assign bus.wr_done     = (state == ST_DONE);
    assign bus.frame_count = count_q;

endmodule

// File: tb/tb_frame_assembler.sv
// Scoreboard bench: transfers are turned into expected frames by chunking word lists,
// and a negedge monitor compares every wr_ready / wr_done against the queue.
module tb_frame_assembler;
    import frame_pkg::*;

    localparam int IW    = 32;
    localparam int DW    = 512;
    localparam int WORDS = DW / IW;
    localparam int DRAIN = 2;

    typedef struct {
        bit          is_done;
        logic [DW-1:0] data;
        int          count;
        bit          last_frame;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_assembler_if #(.IN_WIDTH(IW), .DATAWIDTH(DW)) bus ();

    frame_assembler #(
        .IN_WIDTH     (IW),
        .DATAWIDTH    (DW),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    exp_t          expq[$];
    exp_t          e;
    logic [31:0]   tx_words[$];
    logic [DW-1:0] prev_fd;
    int            last_acc   = -1;
    int            final_cyc  = 0;
    bit            in_tail    = 0;
    bit            tail_bad   = 0;
    bit            after_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] host_to_slot(input logic [31:0] w);
`ifdef FRAME_ASM_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Reference: split the word list into WORDS-sized chunks, zero-pad the tail chunk.
    task automatic build_expected();
        int   n       = tx_words.size();
        int   nframes = (n + WORDS - 1) / WORDS;
        exp_t x;
        for (int f = 0; f < nframes; f++) begin
            x.is_done = 0;
            x.data    = '0;
            for (int k = 0; k < WORDS; k++) begin
                if (f * WORDS + k < n) x.data[k*IW +: IW] = host_to_slot(tx_words[f*WORDS + k]);
            end
            x.count      = (f + 1 > 65535) ? 65535 : f + 1;
            x.last_frame = (f == nframes - 1);
            expq.push_back(x);
        end
        x.is_done    = 1;
        x.data       = '0;
        x.count      = nframes;
        x.last_frame = 0;
        expq.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            in_tail    = 0;
            after_done = 0;
            prev_fd    = bus.frame_data;
        end else begin
            if (bus.wr_ready || bus.wr_done)
                chk("strobe_exclusive", DW'(bus.wr_ready & bus.wr_done), '0);
            if (bus.wr_ready) begin
                if (expq.size() == 0 || expq[0].is_done) begin
                    tests++; fails++;
                    $display("FAIL unexpected_frame actual=wr_ready expected=none data=%0h", bus.frame_data);
                end else begin
                    e = expq.pop_front();
                    chk("frame_data", bus.frame_data, e.data);
                    chk("frame_count_at_strobe", DW'(bus.frame_count), DW'(e.count));
                    chk("frame_latency", DW'(cyc), DW'(last_acc));
                    if (e.last_frame) begin
                        final_cyc = cyc;
                        in_tail   = 1;
                        tail_bad  = 0;
                    end
                end
            end else begin
                chk("frame_data_stable", bus.frame_data, prev_fd);
            end
            if (in_tail && bus.s_ready) tail_bad = 1;
            if (bus.wr_done) begin
                if (expq.size() == 0 || !expq[0].is_done) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done actual=wr_done expected=none");
                end else begin
                    e = expq.pop_front();
                    chk("frame_count_at_done", DW'(bus.frame_count), DW'(e.count));
                    chk("done_gap", DW'(cyc - final_cyc), DW'(DRAIN + 1));
                    chk("s_ready_low_in_tail", DW'(tail_bad), '0);
                end
                in_tail    = 0;
                after_done = 1;
            end else if (after_done) begin
                chk("frame_count_cleared", DW'(bus.frame_count), '0);
                after_done = 0;
            end
            prev_fd = bus.frame_data;
            if (bus.s_valid && bus.s_ready) last_acc = cyc + 1;
        end
    end

    task automatic send_word(input logic [31:0] data, input bit last);
        bit ok = 0;
        bus.s_data  = data;
        bus.s_valid = 1'b1;
        bus.s_last  = last;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL handshake_timeout actual=no_accept expected=accept word=%0h", data);
        end
    endtask

    task automatic idle(input int n);
        bus.s_valid = 1'b0;
        bus.s_data  = $urandom;
        bus.s_last  = 1'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_transfer(input bit gaps);
        build_expected();
        for (int i = 0; i < tx_words.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            send_word(tx_words[i], i == tx_words.size() - 1);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && expq.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_empty", DW'(expq.size()), '0);
    endtask

    task automatic random_words(input int n);
        tx_words.delete();
        for (int i = 0; i < n; i++) tx_words.push_back($urandom | 32'h1);
    endtask

    initial begin
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_s_ready", DW'(bus.s_ready), '0);
        chk("reset_wr_ready", DW'(bus.wr_ready), '0);
        chk("reset_wr_done", DW'(bus.wr_done), '0);
        chk("reset_frame_count", DW'(bus.frame_count), '0);
        chk("reset_frame_data", bus.frame_data, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("s_ready_after_reset", DW'(bus.s_ready), DW'(1));
        @(posedge clk);
        #1;

        // Full frame, s_last on the final slot: exactly one frame, no empty extra.
        tx_words.delete();
        for (int i = 1; i <= WORDS; i++) tx_words.push_back(32'(i));
        send_transfer(0);
        idle(1);
        wait_drain();

        // Partial frame 0xA, 0xB, 0xC.
        tx_words.delete();
        tx_words.push_back(32'hA);
        tx_words.push_back(32'hB);
        tx_words.push_back(32'hC);
        send_transfer(0);
        idle(2);
        wait_drain();

        // 40 words with random gaps: three frames, last one with 8 slots used.
        random_words(40);
        send_transfer(1);
        idle(1);
        wait_drain();

        // s_last on word 0.
        random_words(1);
        send_transfer(0);
        idle(1);
        wait_drain();

        // Back-to-back transfers with s_valid held high through DRAIN/DONE.
        random_words(5);
        send_transfer(0);
        random_words(20);
        send_transfer(1);
        idle(1);
        wait_drain();

        // Mid-transfer reset: seven words are discarded without a frame.
        for (int i = 0; i < 7; i++) send_word(32'hDEAD0000 | 32'(i), 1'b0);
        bus.s_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        random_words(WORDS);
        send_transfer(0);
        idle(1);
        wait_drain();

        // Byte order of a known word.
        tx_words.delete();
        tx_words.push_back(32'h11223344);
        send_transfer(0);
        idle(1);
        wait_drain();

        // Random transfer lengths around frame boundaries.
        for (int t = 0; t < 6; t++) begin
            random_words($urandom_range(1, 3 * WORDS));
            send_transfer(1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
        end
        idle(1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_assembler.md
Name: frame_assembler

Overview:
- Upstream neighbour of the frame unpacker: gathers a narrow host word stream (valid/ready, with last marker) into DATAWIDTH-bit frames.
- Drives `frame_data`, `wr_ready` and `wr_done` directly into the unpacker's identically named inputs.
- Pads the final partial frame with zeros, then signals end of transfer after a fixed drain gap so the downstream FSM can settle in its idle state.

Parameters:
- IN_WIDTH, 32, host word width; DATAWIDTH must be an integer multiple of it.
- DATAWIDTH, 512, frame width delivered downstream.
- DRAIN_CYCLES, 2, idle cycles between the final `wr_ready` strobe and `wr_done`; legal range 1..15.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- s_data  input  IN_WIDTH  host word.
- s_valid  input  1  host word valid.
- s_last  input  1  marks final word of a transfer; qualified by s_valid.
- s_ready  output  1  word accepted when s_valid && s_ready.
- frame_data  output  DATAWIDTH  assembled frame; held until the next frame is produced.
- wr_ready  output  1  one-cycle strobe per completed frame; frame_data is valid from this cycle.
- wr_done  output  1  one-cycle end-of-transfer pulse.
- frame_count  output  16  frames emitted in the current transfer; saturates at 0xFFFF.

Behaviour:
- Reset values: s_ready=0, frame_data=0, wr_ready=0, wr_done=0, frame_count=0; accumulator and word index cleared; state=FILL.
- Reset mid-transfer discards the partial frame and emits nothing.
- Constant: WORDS = DATAWIDTH/IN_WIDTH. Word index is $clog2(WORDS) bits and wraps to 0 after a frame completes.
- Packing: the k-th word of a frame lands at bits [k*IN_WIDTH +: IN_WIDTH]. The first word occupies the LSBs.
- FSM state FILL:
  - s_ready=1 (from the first cycle after reset).
  - On each accepted word: write the accumulator, index+1.
  - If index==WORDS-1 or s_last: at the next edge frame_data <= assembled frame with unwritten slots zero, wr_ready=1 for one cycle, frame_count+1 (saturating), index<=0, accumulator cleared.
  - If s_last: go to DRAIN. Otherwise stay in FILL.
  - A new word may be accepted in the same cycle wr_ready is high; there is no stall between frames.
- FSM state DRAIN:
  - s_ready=0, wr_ready=0.
  - Counter runs DRAIN_CYCLES cycles, then go to DONE.
- FSM state DONE:
  - s_ready=0, wr_done=1 for exactly one cycle.
  - Next cycle: frame_count<=0, go to FILL.
- Latency, word to frame: the completing word accepted at edge t gives wr_ready high in cycle t+1. With DRAIN_CYCLES=2, wr_done is high in cycle t+4.
- Boundary conditions:
  - s_last on word WORDS-1 gives exactly one frame, with no extra empty frame.
  - s_last on word 0 gives one frame whose only nonzero slot is slot 0.
  - s_valid low in any state has no effect.
  - s_data, s_valid and s_last are ignored while s_ready=0.
  - wr_ready and wr_done are never high in the same cycle.
- Invariant: frame_data is stable whenever wr_ready=0.

Optional Feature:
- Macro: FRAME_ASM_BYTESWAP_EN.
- Defined: each accepted s_data word is byte-reversed before packing, converting big-endian host words. IN_WIDTH must be a multiple of 8.
- Undefined: words are packed unmodified.
- No port or timing difference between the two builds.

Decomposition:
- Shared package `frame_pkg`, also imported by the unpacker:
  - DATAWIDTH and IN_WIDTH defaults.
  - WORDS derivation.
  - frame_count width constant (16).
  - State enum {FILL, DRAIN, DONE}.
- One natural sub-module: `word_packer`.
  - Contents: accumulator, index counter, zero-pad and optional byteswap.
  - Outputs: `full`, the packed vector, and a clear input.
- The FSM and the drain counter stay in frame_assembler.

Test Plan:
- Reset check: hold rst 3 cycles → all outputs 0; s_ready=1 on the first cycle after release.
- Full frame: 16 words 0x00000001..0x00000010 back-to-back, s_last on 16th → one wr_ready strobe, one cycle after last accept.
  - frame_data[31:0]=0x1, frame_data[511:480]=0x10.
  - wr_done exactly 3 cycles after that strobe.
  - frame_count=1 at wr_done.
- Partial frame: 3 words 0xA,0xB,0xC with s_last → frame_data[95:0]={0xC,0xB,0xA}, bits [511:96]=0; single wr_ready strobe.
- Multi-frame with gaps: 40 words with random s_valid gaps, s_last on word 40 → 3 strobes (last frame has 8 nonzero slots); frame_data stable between strobes; frame_count=3 at wr_done.
- Backpressure and restart: keep s_valid=1 after s_last → s_ready=0 through DRAIN and DONE, no word lost. The next transfer starts in FILL with frame_count=0.
- Mid-transfer reset: rst asserted after word 7 → no wr_ready. After release, 16 fresh words produce a frame with no residue of the first 7. With FRAME_ASM_BYTESWAP_EN, input 0x11223344 appears as 0x44332211.
